// File: rtl/ro_puf_pkg.sv
// Shared definitions for the ring-oscillator PUF evaluator.
// Holds the parameter defaults, the FSM state encoding and small
// elaboration-time helpers used to size internal counters.
package ro_puf_pkg;

    localparam int unsigned CNT_W_DEF         = 16;
    localparam int unsigned WINDOW_CYCLES_DEF = 1024;
    localparam int unsigned SETTLE_CYCLES_DEF = 8;
    localparam int unsigned SYNC_STAGES_DEF   = 2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_COUNT   = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_COMPARE = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    // Bits needed to hold values 0..max_val (at least one bit).
    function automatic int unsigned cnt_bits(input int unsigned max_val);
        return (max_val == 0) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/ro_puf_eval_edge_counter.sv
// Per-oscillator front end: SYNC_STAGES-deep synchronizer, rising-edge
// detector on the synchronized signal and a saturating edge counter.
// Ports:
//   clk, rst  - clock and synchronous active-high reset (clears everything)
//   clr       - clears the edge counter only
//   cnt_en    - detected edges are counted only while this is high
//   ro_in     - asynchronous ring-oscillator output
//   count     - current edge count (registered, saturating)
module ro_edge_counter
    import ro_puf_pkg::*;
#(
    parameter int unsigned CNT_W       = CNT_W_DEF,
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             cnt_en,
    input  logic             ro_in,
    output logic [CNT_W-1:0] count
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic [CNT_W-1:0]       r_count;
    logic                   w_edge;
    logic                   w_sat;

    assign w_edge = r_sync[SYNC_STAGES-1] & ~r_prev;
    assign w_sat  = &r_count;
    assign count  = r_count;

    // Synchronizer, edge history and saturating counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync  <= '0;
            r_prev  <= 1'b0;
            r_count <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], ro_in};
            r_prev <= r_sync[SYNC_STAGES-1];
            if (clr) begin
                r_count <= '0;
            end else if (cnt_en && w_edge && !w_sat) begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/ro_puf_eval.sv
// Ring-oscillator PUF evaluator: enables two oscillators, lets them settle,
// counts their synchronized rising edges over a fixed window, drains the
// synchronizer pipeline and compares the two counts into one response bit.
// Ports:
//   clk, rst           - clock, synchronous active-high reset
//   start              - evaluation request, sampled only in IDLE
//   ro_a, ro_b         - asynchronous oscillator outputs
//   en_a, en_b         - oscillator enables (SETTLE and COUNT)
//   busy               - high whenever not IDLE
//   done               - one-cycle pulse when results are valid
//   response, tie      - count_a > count_b, count_a == count_b
//   count_a, count_b   - final edge counts
module ro_puf_eval
    import ro_puf_pkg::*;
#(
    parameter int unsigned CNT_W         = CNT_W_DEF,
    parameter int unsigned WINDOW_CYCLES = WINDOW_CYCLES_DEF,
    parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEF,
    parameter int unsigned SYNC_STAGES   = SYNC_STAGES_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             ro_a,
    input  logic             ro_b,
    output logic             en_a,
    output logic             en_b,
    output logic             busy,
    output logic             done,
    output logic             response,
    output logic             tie,
    output logic [CNT_W-1:0] count_a,
    output logic [CNT_W-1:0] count_b
);

    // One down-counter times SETTLE, COUNT and DRAIN in turn.
    localparam int unsigned TMR_MAX = max3(WINDOW_CYCLES - 1, SETTLE_CYCLES - 1, SYNC_STAGES);
    localparam int unsigned TMR_W   = cnt_bits(TMR_MAX);

    state_t           r_state;
    state_t           w_next;
    logic [TMR_W-1:0] r_timer;
    logic [TMR_W-1:0] w_timer_nxt;
    logic             w_clr;
    logic             w_cnt_en;
    logic             w_load;
    logic             r_en;
    logic             r_busy;
    logic             r_done;
    logic             r_resp;
    logic             r_tie;
    logic [CNT_W-1:0] w_cnt_a;
    logic [CNT_W-1:0] w_cnt_b;

    // State, timer and state-decoded outputs, registered from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_timer <= '0;
            r_en    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_timer <= w_timer_nxt;
            r_en    <= (w_next == ST_SETTLE) || (w_next == ST_COUNT);
            r_busy  <= (w_next != ST_IDLE);
            r_done  <= (w_next == ST_DONE);
        end
    end

    // Next-state, timer reload and counter control.
    always_comb begin
        w_next      = r_state;
        w_timer_nxt = r_timer;
        w_clr       = 1'b0;
        w_cnt_en    = 1'b0;
        w_load      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next      = ST_SETTLE;
                    w_clr       = 1'b1;
                    w_timer_nxt = TMR_W'(SETTLE_CYCLES - 1);
                end
            end
            ST_SETTLE: begin
                if (r_timer == '0) begin
                    w_next      = ST_COUNT;
                    w_timer_nxt = TMR_W'(WINDOW_CYCLES - 1);
                end else begin
                    w_timer_nxt = r_timer - TMR_W'(1);
                end
            end
            ST_COUNT: begin
                w_cnt_en = 1'b1;
                if (r_timer == '0) begin
                    w_next      = ST_DRAIN;
                    w_timer_nxt = TMR_W'(SYNC_STAGES);
                end else begin
                    w_timer_nxt = r_timer - TMR_W'(1);
                end
            end
            ST_DRAIN: begin
                // Edges still in the synchronizer are counted here.
                w_cnt_en = 1'b1;
                if (r_timer == '0) begin
                    w_next = ST_COMPARE;
                end else begin
                    w_timer_nxt = r_timer - TMR_W'(1);
                end
            end
            ST_COMPARE: begin
                w_load = 1'b1;
                w_next = ST_DONE;
            end
            ST_DONE: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Result bits; held until the next accepted start.
    always_ff @(posedge clk) begin
        if (rst || w_clr) begin
            r_resp <= 1'b0;
            r_tie  <= 1'b0;
        end else if (w_load) begin
            r_resp <= (w_cnt_a > w_cnt_b);
            r_tie  <= (w_cnt_a == w_cnt_b);
        end
    end

    ro_edge_counter #(
        .CNT_W       (CNT_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_cnt_a (
        .clk    (clk),
        .rst    (rst),
        .clr    (w_clr),
        .cnt_en (w_cnt_en),
        .ro_in  (ro_a),
        .count  (w_cnt_a)
    );

    ro_edge_counter #(
        .CNT_W       (CNT_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_cnt_b (
        .clk    (clk),
        .rst    (rst),
        .clr    (w_clr),
        .cnt_en (w_cnt_en),
        .ro_in  (ro_b),
        .count  (w_cnt_b)
    );

    assign en_a     = r_en;
    assign en_b     = r_en;
    assign busy     = r_busy;
    assign done     = r_done;
    assign response = r_resp;
    assign tie      = r_tie;
    assign count_a  = w_cnt_a;
    assign count_b  = w_cnt_b;

endmodule

// File: tb/tb_ro_puf_eval.sv
// Bench for ro_puf_eval: two instances (16-bit and 2-bit counters) share
// the same stimulus. Oscillator waveforms come from a generator; every
// sampled value is logged and the expected counts are the number of 0->1
// transitions of that log inside the counting window seen at the
// synchronizer input, clipped to the counter range.
module tb_ro_puf_eval;

    localparam int W    = 16;
    localparam int S    = 4;
    localparam int SY   = 2;
    localparam int CW   = 16;
    localparam int CWS  = 2;
    localparam int LAT  = S + W + SY + 2;
    localparam int MAXC = 8192;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic ro_a;
    logic ro_b;

    logic          d_en_a, d_en_b, d_busy, d_done, d_resp, d_tie;
    logic [CW-1:0] d_count_a, d_count_b;
    logic          s_en_a, s_en_b, s_busy, s_done, s_resp, s_tie;
    logic [CWS-1:0] s_count_a, s_count_b;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit sa [MAXC];
    bit sb [MAXC];

    // Generator settings: mode 0 constant, 1 square wave, 2 random bits.
    int mode_a = 0, per_a = 4, ref_a = 0, lvl_a = 0;
    int mode_b = 0, per_b = 4, ref_b = 0, lvl_b = 0;

    ro_puf_eval #(.CNT_W(CW), .WINDOW_CYCLES(W), .SETTLE_CYCLES(S), .SYNC_STAGES(SY)) u_dut (
        .clk(clk), .rst(rst), .start(start), .ro_a(ro_a), .ro_b(ro_b),
        .en_a(d_en_a), .en_b(d_en_b), .busy(d_busy), .done(d_done),
        .response(d_resp), .tie(d_tie), .count_a(d_count_a), .count_b(d_count_b));

    ro_puf_eval #(.CNT_W(CWS), .WINDOW_CYCLES(W), .SETTLE_CYCLES(S), .SYNC_STAGES(SY)) u_sat (
        .clk(clk), .rst(rst), .start(start), .ro_a(ro_a), .ro_b(ro_b),
        .en_a(s_en_a), .en_b(s_en_b), .busy(s_busy), .done(s_done),
        .response(s_resp), .tie(s_tie), .count_a(s_count_a), .count_b(s_count_b));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic gen(input int mode, input int per, input int rf, input int lvl, input int k);
        int m;
        case (mode)
            0: return lvl[0];
            1: begin
                m = (k - rf) % per;
                if (m < 0) m += per;
                return (m >= per / 2);
            end
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    // Log what the first synchronizer flop captures at each edge; a reset
    // also wipes the history still held in the synchronizer and edge flop.
    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
        if (cyc < MAXC) begin
            sa[cyc] = rst ? 1'b0 : ro_a;
            sb[cyc] = rst ? 1'b0 : ro_b;
            if (rst) begin
                for (int i = 1; i <= SY; i++) begin
                    if (cyc - i >= 0) begin
                        sa[cyc - i] = 1'b0;
                        sb[cyc - i] = 1'b0;
                    end
                end
            end
        end
    end

    // Oscillator drive changes on the falling edge for the next rising edge.
    initial forever begin
        @(negedge clk);
        ro_a = gen(mode_a, per_a, ref_a, lvl_a, cyc + 1);
        ro_b = gen(mode_b, per_b, ref_b, lvl_b, cyc + 1);
    end

    // Rising transitions whose samples reach the counter while it counts.
    function automatic int model_cnt(input bit use_b, input int e0, input int cw);
        int raw;
        int sat;
        raw = 0;
        sat = (1 << cw) - 1;
        for (int k = e0 + S + 1 - SY; k <= e0 + S + W + 1; k++) begin
            if (use_b ? (sb[k] && !sb[k-1]) : (sa[k] && !sa[k-1])) raw++;
        end
        return (raw > sat) ? sat : raw;
    endfunction

    task automatic check_results(input string tag, input int e0);
        int ea, eb, xa, xb;
        ea = model_cnt(1'b0, e0, CW);
        eb = model_cnt(1'b1, e0, CW);
        xa = model_cnt(1'b0, e0, CWS);
        xb = model_cnt(1'b1, e0, CWS);
        chk({tag, "/cnt_a"}, 32'(d_count_a), 32'(ea));
        chk({tag, "/cnt_b"}, 32'(d_count_b), 32'(eb));
        chk({tag, "/resp"},  32'(d_resp),    32'(ea > eb));
        chk({tag, "/tie"},   32'(d_tie),     32'(ea == eb));
        chk({tag, "/s_cnt_a"}, 32'(s_count_a), 32'(xa));
        chk({tag, "/s_cnt_b"}, 32'(s_count_b), 32'(xb));
        chk({tag, "/s_resp"},  32'(s_resp),    32'(xa > xb));
        chk({tag, "/s_tie"},   32'(s_tie),     32'(xa == xb));
    endtask

    // hold: 0 drop start after one cycle, 1 keep it high, 2 random pulses.
    task automatic run_eval(input string tag, input int hold, output int e0);
        bit seen;
        int done_at;
        @(negedge clk);
        start = 1'b1;
        e0 = cyc + 1;
        seen = 1'b0;
        done_at = -1;
        for (int d = 0; d <= LAT + 4 && !seen; d++) begin
            @(negedge clk);
            chk({tag, "/busy"}, 32'({d_busy, s_busy}), 32'(2'b11));
            chk({tag, "/en"}, 32'({d_en_a, d_en_b, s_en_a, s_en_b}), (d < S + W) ? 32'hF : 32'h0);
            chk({tag, "/done"}, 32'({d_done, s_done}), (d == LAT) ? 32'h3 : 32'h0);
            if (d_done) begin
                seen = 1'b1;
                done_at = cyc;
            end
            if (hold == 0) start = 1'b0;
            else if (hold == 2) start = 1'($urandom_range(0, 1));
        end
        chk({tag, "/latency"}, 32'(done_at - e0), 32'(LAT));
        check_results(tag, e0);
        @(negedge clk);
        start = 1'b0;
        chk({tag, "/after"}, 32'({d_done, d_busy, s_done, s_busy}), 32'h0);
        check_results({tag, "/hold"}, e0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int e0, base, e1, t0, t1;
        bit bad_done;
        int dq[$];
        rst = 1'b1;
        start = 1'b0;
        ro_a = 1'b0;
        ro_b = 1'b0;
        repeat (5) @(negedge clk);
        chk("reset/flags", 32'({d_en_a, d_en_b, d_busy, d_done, d_resp, d_tie,
                                s_en_a, s_en_b, s_busy, s_done, s_resp, s_tie}), 32'h0);
        chk("reset/counts", 32'({d_count_a, d_count_b, s_count_a, s_count_b}), 32'h0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Period 4 vs 8, phased so four and two rising edges fall in the window.
        @(negedge clk);
        base = cyc + 2;
        mode_a = 1; per_a = 4; ref_a = base + 4;
        mode_b = 1; per_b = 8; ref_b = base + 2;
        run_eval("p4_p8", 0, e0);
        chk("p4_p8/e0", 32'(e0), 32'(base));
        chk("p4_p8/fixed", 32'({d_count_a, d_count_b, 14'(0), d_resp, d_tie}), {16'd4, 16'd2, 14'd0, 2'b10});
        chk("p4_p8/sat_a", 32'(s_count_a), 32'd3);

        @(negedge clk);
        base = cyc + 2;
        mode_a = 1; per_a = 8; ref_a = base + 2;
        mode_b = 1; per_b = 4; ref_b = base + 4;
        run_eval("p8_p4", 0, e0);
        chk("p8_p4/fixed", 32'({d_count_a, d_count_b, 14'(0), d_resp, d_tie}), {16'd2, 16'd4, 14'd0, 2'b00});

        @(negedge clk);
        base = cyc + 2;
        mode_a = 1; per_a = 6; ref_a = base;
        mode_b = 1; per_b = 6; ref_b = base;
        run_eval("p6_p6", 0, e0);
        chk("p6_p6/fixed", 32'({d_resp, d_tie}), 32'(2'b01));

        // Fast oscillator against a constant input.
        @(negedge clk);
        mode_a = 1; per_a = 2; ref_a = 0;
        mode_b = 0; lvl_b = 1;
        run_eval("sat", 0, e0);
        chk("sat/s_cnt_a", 32'(s_count_a), 32'd3);
        chk("sat/const_b", 32'({d_count_b, s_count_b}), 32'h0);

        // Reset during COUNT aborts with no done pulse.
        mode_a = 1; per_a = 4; ref_a = 1;
        mode_b = 1; per_b = 5; ref_b = 3;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (S + 5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst/flags", 32'({d_en_a, d_en_b, d_busy, d_done, d_resp, d_tie,
                                  s_en_a, s_en_b, s_busy, s_done, s_resp, s_tie}), 32'h0);
        chk("mid_rst/counts", 32'({d_count_a, d_count_b, s_count_a, s_count_b}), 32'h0);
        bad_done = 1'b0;
        repeat (LAT + 10) begin
            @(negedge clk);
            if (d_done || s_done || d_busy) bad_done = 1'b1;
        end
        chk("mid_rst/no_done", 32'(bad_done), 32'h0);
        run_eval("post_rst", 0, e0);

        // Reset wins over start in the same cycle.
        @(negedge clk);
        rst = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        chk("rst_prio/busy", 32'({d_busy, s_busy}), 32'h0);
        @(negedge clk);
        chk("rst_prio/idle", 32'({d_busy, s_busy}), 32'h0);

        // Start held high or toggled during busy: exactly one done each.
        run_eval("hold_start", 1, e0);
        run_eval("pulse_start", 2, e0);

        // Start held high continuously: back-to-back evaluations.
        mode_a = 2; mode_b = 2;
        @(negedge clk);
        start = 1'b1;
        t0 = cyc + 1;
        for (int i = 0; i < 2 * LAT + 20 && dq.size() < 2; i++) begin
            @(negedge clk);
            if (d_done) begin
                dq.push_back(cyc);
                if (dq.size() == 2) start = 1'b0;
            end
        end
        chk("b2b/n_done", 32'(dq.size()), 32'd2);
        if (dq.size() == 2) begin
            t1 = dq[1];
            chk("b2b/first", 32'(dq[0] - t0), 32'(LAT));
            chk("b2b/second", 32'(t1 - t0), 32'(2 * LAT + 2));
            e1 = t0 + LAT + 2;
            check_results("b2b", e1);
        end
        @(negedge clk);
        @(negedge clk);
        chk("b2b/idle", 32'({d_busy, d_done}), 32'h0);

        // Randomized waveforms.
        for (int it = 0; it < 16; it++) begin
            @(negedge clk);
            mode_a = $urandom_range(0, 2); per_a = $urandom_range(2, 12);
            ref_a = $urandom_range(0, 31); lvl_a = $urandom_range(0, 1);
            mode_b = $urandom_range(0, 2); per_b = $urandom_range(2, 12);
            ref_b = $urandom_range(0, 31); lvl_b = $urandom_range(0, 1);
            run_eval($sformatf("rand%0d", it), $urandom_range(0, 2), e0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
